// File: rtl/frame_payload_extractor.sv
// frame_payload_extractor
// Takes the aligned byte stream from the frame aligner, drops the header bytes
// and stages each frame's payload in a packet-mode FIFO. A payload becomes
// visible to the consumer only once its last byte has arrived in sequence;
// any break in the sequence rolls the speculative write pointer back.
module frame_payload_extractor #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 12,
  parameter int HDR_LEN   = 2,
  parameter int DEPTH     = 32,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [3:0]        fr_byte_position,
  input  logic              frame_detect,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  abort_cnt,
  output logic [CNT_W-1:0]  ovf_cnt
);

  localparam int PAYLOAD_LEN = FRAME_LEN - HDR_LEN;
  localparam int AW          = $clog2(DEPTH);
  localparam int PW          = AW + 1;

  localparam logic [3:0] POS_HDR  = 4'(HDR_LEN);
  localparam logic [3:0] POS_LAST = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_t;

  // Saturating increment shared by all status counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Storage: each entry holds {last, data}. Data is not reset; pointers gate visibility.
  logic [DATA_W:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [3:0]      exp_q, exp_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] frame_cnt_q, abort_cnt_q, ovf_cnt_q;

  logic            wr_en;
  logic            wr_last;
  logic            inc_frame, inc_abort, inc_ovf;
  logic [PW-1:0]   used;
  logic [31:0]     free_slots;
  logic            room_ok;
  logic            start_hit;
  logic            rd_fire;
  logic [DATA_W:0] head;

  // Space check uses the pre-edge read pointer: a read on this edge is not credited.
  always_comb begin
    used       = wr_ptr_q - rd_ptr_q;
    free_slots = 32'(DEPTH) - {{(32-PW){1'b0}}, used};
    room_ok    = (free_slots >= 32'(PAYLOAD_LEN));
    start_hit  = frame_detect && (fr_byte_position == POS_HDR);
  end

  // Frame FSM: decides writes, commit, rollback and counter events.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    wr_last      = 1'b0;
    inc_frame    = 1'b0;
    inc_abort    = 1'b0;
    inc_ovf      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_hit) begin
          if (room_ok) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            exp_d    = POS_HDR + 4'd1;
            state_d  = COLLECT;
          end else begin
            inc_ovf = 1'b1;
            state_d = DROP;
          end
        end
      end
      COLLECT: begin
        if (frame_detect && (fr_byte_position == exp_q)) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          exp_d    = exp_q + 4'd1;
          if (fr_byte_position == POS_LAST) begin
            wr_last      = 1'b1;
            commit_ptr_d = wr_ptr_q + 1'b1;
            inc_frame    = 1'b1;
            state_d      = IDLE;
          end
        end else begin
          // Sequence broken: discard the partial payload; the offending byte is dropped.
          wr_ptr_d  = commit_ptr_q;
          inc_abort = 1'b1;
          state_d   = IDLE;
        end
      end
      DROP: begin
        if (!frame_detect || (fr_byte_position == POS_LAST)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read side: first-word fall-through head of the committed region.
  always_comb begin
    head      = mem[rd_ptr_q[AW-1:0]];
    out_valid = (commit_ptr_q != rd_ptr_q);
    out_data  = out_valid ? head[DATA_W-1:0] : '0;
    out_last  = out_valid ? head[DATA_W] : 1'b0;
    rd_fire   = out_valid && out_ready;
    rd_ptr_d  = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Payload storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {wr_last, rx_data};
    end
  end

  // Control state, pointers and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      frame_cnt_q  <= '0;
      abort_cnt_q  <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      if (inc_frame) frame_cnt_q <= sat_inc(frame_cnt_q);
      if (inc_abort) abort_cnt_q <= sat_inc(abort_cnt_q);
      if (inc_ovf)   ovf_cnt_q   <= sat_inc(ovf_cnt_q);
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: doc/frame_payload_extractor.md
Name: frame_payload_extractor

Overview:
- Sits directly downstream of the frame aligner. Consumes its byte stream (rx_data, fr_byte_position, frame_detect).
- Strips header bytes and buffers each frame's payload in a packet-mode FIFO.
- Releases a payload only after the whole frame arrives intact; partial frames are discarded.
- Presents payload bytes on a valid/ready stream with an end-of-frame marker for the next processing stage.

Parameters:
DATA_W, 8, byte width of rx_data and out_data
FRAME_LEN, 12, bytes per frame including header
HDR_LEN, 2, header bytes at positions 0..HDR_LEN-1; payload is HDR_LEN..FRAME_LEN-1 (PAYLOAD_LEN = 10)
DEPTH, 32, FIFO entries; power of 2, must be >= PAYLOAD_LEN
CNT_W, 8, width of status counters

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rx_data  input  DATA_W  byte from aligner, same cycle as its position
fr_byte_position  input  4  position of rx_data within frame, 0..FRAME_LEN-1
frame_detect  input  1  aligner locked; position valid only when high
out_data  output  DATA_W  head payload byte
out_last  output  1  head byte is last payload byte of its frame
out_valid  output  1  committed byte available
out_ready  input  1  consumer accepts byte
frame_cnt  output  CNT_W  frames committed, saturating
abort_cnt  output  CNT_W  frames discarded mid-frame, saturating
ovf_cnt  output  CNT_W  frames dropped for lack of space, saturating

Behaviour:
- Reset, sync active-high: all pointers 0; state IDLE; out_valid, out_data, out_last 0; all counters 0. Reset mid-frame discards uncommitted and committed data.
- FIFO entries are {last, data}. Pointers are log2(DEPTH)+1 bits: wr_ptr (speculative), commit_ptr, rd_ptr.
- free = DEPTH - (wr_ptr - rd_ptr), using pre-edge rd_ptr. A same-cycle read is not credited.
- FSM states:
  - IDLE: on frame_detect && pos==HDR_LEN:
    - if free >= PAYLOAD_LEN: write byte, expected = HDR_LEN+1, go to COLLECT;
    - else: ovf_cnt++, go to DROP.
    - All other inputs are ignored.
  - COLLECT: on frame_detect && pos==expected: write byte, expected++.
    - If pos==FRAME_LEN-1: write with last=1; commit_ptr <= wr_ptr+1 on the same edge; frame_cnt++; go to IDLE.
    - If frame_detect==0 or pos!=expected: wr_ptr <= commit_ptr (rollback); abort_cnt++; go to IDLE. The offending byte is discarded and not re-evaluated as a frame start.
  - DROP: go to IDLE when frame_detect==0 or pos==FRAME_LEN-1. Nothing is written.
- Output, first-word fall-through:
  - out_valid = (commit_ptr != rd_ptr), registered-state derived.
  - out_data and out_last reflect the entry at rd_ptr; both are 0 when out_valid==0.
  - Transfer on out_valid && out_ready; rd_ptr++. out_ready is ignored while out_valid==0.
- Latency:
  - The last payload byte is sampled at edge N.
  - out_valid rises after edge N, presenting the frame's first payload byte.
  - With out_ready held high, the frame streams out in PAYLOAD_LEN consecutive cycles.
- Simultaneous events:
  - Commit and read on the same edge are both applied.
  - Rollback never touches rd_ptr or committed data.
  - A read during COLLECT is allowed; it reads committed data only.
- Counters saturate at all-ones.
- Header bytes (pos < HDR_LEN) are never stored.

Test Plan:
- Three back-to-back locked frames, payload 0x01..0x0A, out_ready=1 -> 30 bytes out in order, out_last only on 0x0A. out_valid rises the cycle after each pos-11 byte. frame_cnt=3, other counters 0.
- frame_detect drops at pos 6 of frame 1; frame 2 complete with payload 0x11..0x1A -> only 0x11..0x1A output; abort_cnt=1, frame_cnt=1.
- Locked stream jumps from pos 3 to pos 5 -> frame discarded, abort_cnt=1. Next frame starting at pos 2 is captured fully (10 bytes out).
- out_ready=0, DEPTH=32, four complete frames -> frames 1-3 committed (30 entries), frame 4 dropped, ovf_cnt=1. Then out_ready=1 -> exactly 30 bytes, 3 out_last pulses.
- Reset asserted for 1 cycle while in COLLECT with 10 committed bytes -> out_valid=0 and all counters 0 after the edge. A following complete frame outputs 10 bytes correctly.
- out_ready toggles every cycle across 5 frames -> 50 bytes out, no loss or duplication, order preserved, out_data stable while out_valid && !out_ready.
